// File: rtl/dmem_responder.sv
// Data-memory responder for the execute-stage load/store port.
// Address regions: 00/01 on-chip RAM, 10 memory-mapped registers, 11 slow
// wait-stated register array. Load data is registered and appears the cycle
// after acceptance; slow accesses hold the requester through stall_o.
//
// state  | meaning
// IDLE   | no slow access pending; a slow request here starts the wait
// WAIT   | counting down wait states; the access is accepted when cnt == 0
module dmem_responder #(
    parameter int ADDR        = 16,
    parameter int W_OPR       = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 3,
    parameter int SLOW_LOG2   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_i,
    input  logic [ADDR-1:0]  addr_i,
    input  logic             write_i,
    input  logic [W_OPR-1:0] data_i,
    output logic [W_OPR-1:0] data_o,
    output logic             stall_o,
    output logic [W_OPR-1:0] dbg_out_o,
    output logic             busy_o
);

    localparam int               RAM_WORDS  = 1 << DEPTH_LOG2;
    localparam int               SLOW_WORDS = 1 << SLOW_LOG2;
    localparam logic [W_OPR-1:0] ID_VALUE   = W_OPR'(32'h5645_4E55);
    localparam logic [3:0]       CNT_LOAD   = 4'(WAIT_CYCLES - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [W_OPR-1:0] ram [RAM_WORDS];
    logic [W_OPR-1:0] slow_mem [SLOW_WORDS];
    logic [W_OPR-1:0] cyc_cnt;
    logic [W_OPR-1:0] scratch;
    logic [W_OPR-1:0] dbg_reg;
    logic [W_OPR-1:0] rd_data;

    logic [1:0]            region;
    logic                  is_ram;
    logic                  is_mmio;
    logic                  is_slow;
    logic                  wait_done;
    logic                  accept;
    logic                  do_store;
    logic                  do_load;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [SLOW_LOG2-1:0]  slow_idx;
    logic [1:0]            mmio_off;
    logic                  unused_addr;

    assign region    = addr_i[ADDR-1 -: 2];
    assign is_ram    = ~region[1];
    assign is_mmio   = (region == 2'b10);
    assign is_slow   = (region == 2'b11);
    assign ram_idx   = addr_i[DEPTH_LOG2-1:0];
    assign slow_idx  = addr_i[SLOW_LOG2-1:0];
    assign mmio_off  = addr_i[1:0];
    assign unused_addr = ^addr_i;

    // Reset is folded in so the stall drops the moment reset is asserted,
    // even while the requester still holds a slow request.
    assign wait_done = (state == S_WAIT) && (cnt == 4'd0);
    assign stall_o   = reset && req_i && is_slow && !wait_done;
    assign accept    = reset && req_i && !stall_o;
    assign do_store  = accept && write_i;
    assign do_load   = accept && !write_i;
    assign busy_o    = (state == S_WAIT);
    assign dbg_out_o = dbg_reg;

    // Load data mux across the three regions.
    always_comb begin
        rd_data = '0;
        if (is_ram) begin
            rd_data = ram[ram_idx];
        end else if (is_mmio) begin
            case (mmio_off)
                2'd0:    rd_data = cyc_cnt;
                2'd1:    rd_data = scratch;
                2'd2:    rd_data = dbg_reg;
                default: rd_data = ID_VALUE;
            endcase
        end else begin
            rd_data = slow_mem[slow_idx];
        end
    end

    // Slow-region wait-state sequencer; a dropped request abandons the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_i && is_slow) begin
                        state <= S_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (!(req_i && is_slow) || cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM and slow array store ports; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_store && is_ram)  ram[ram_idx]       <= data_i;
        if (do_store && is_slow) slow_mem[slow_idx] <= data_i;
    end

    // MMIO registers, free-running counter and registered load data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= '0;
            scratch <= '0;
            dbg_reg <= '0;
            data_o  <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (do_store && is_mmio && mmio_off == 2'd1) scratch <= data_i;
            if (do_store && is_mmio && mmio_off == 2'd2) dbg_reg <= data_i;
            if (do_load) data_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: reference model of the memory map and wait-state
// timing, compared against the outputs on every falling edge, plus directed
// literal expectations for the key scenarios.
module tb_dmem_responder;

    localparam int WC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] data_o;
    logic        stall_o;
    logic [31:0] dbg_out_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR(16), .W_OPR(32), .DEPTH_LOG2(10), .WAIT_CYCLES(WC), .SLOW_LOG2(4)
    ) dut (
        .clk(clk), .reset(rst_n), .req_i(req), .addr_i(addr), .write_i(wr),
        .data_i(din), .data_o(data_o), .stall_o(stall_o),
        .dbg_out_o(dbg_out_o), .busy_o(busy_o)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_ram [1024];
    logic [31:0] m_slow [16];
    logic [31:0] m_data, m_dbg, m_scr, m_cnt;
    int          m_age;   // cycles the current slow request has been held off

    function automatic logic [31:0] initv(int i);
        return 32'(i) * 32'h9E37_79B9 + 32'd1;
    endfunction

    function automatic bit exp_stall();
        return rst_n && req && (addr[15:14] == 2'b11) && (m_age < WC);
    endfunction

    function automatic logic [31:0] model_read(logic [15:0] a);
        case (a[15:14])
            2'b00, 2'b01: return m_ram[a[9:0]];
            2'b10: begin
                case (a[1:0])
                    2'd0:    return m_cnt;
                    2'd1:    return m_scr;
                    2'd2:    return m_dbg;
                    default: return 32'h5645_4E55;
                endcase
            end
            default: return m_slow[a[3:0]];
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data = '0; m_dbg = '0; m_scr = '0; m_cnt = '0; m_age = 0;
        end else begin
            bit st;
            st = exp_stall();
            if (req && !st) begin
                if (!wr) m_data = model_read(addr);
                else begin
                    case (addr[15:14])
                        2'b00, 2'b01: m_ram[addr[9:0]] = din;
                        2'b10: begin
                            if (addr[1:0] == 2'd1) m_scr = din;
                            if (addr[1:0] == 2'd2) m_dbg = din;
                        end
                        default: m_slow[addr[3:0]] = din;
                    endcase
                end
            end
            if (req && addr[15:14] == 2'b11) m_age = st ? m_age + 1 : 0;
            else m_age = 0;
            m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("stall", {31'd0, stall_o}, {31'd0, exp_stall()});
        chk("busy", {31'd0, busy_o}, {31'd0, m_age > 0});
        chk("data", data_o, m_data);
        chk("dbg", dbg_out_o, m_dbg);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(logic [15:0] a, logic w, logic [31:0] d);
        int n;
        req = 1'b1; addr = a; wr = w; din = d;
        #1;
        n = 0;
        while (stall_o && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("stall_timeout", 32'(n), 32'd0);
        step();
        req = 1'b0;
    endtask

    initial begin
        logic [15:0] ra;
        // Reset state
        step(); step();
        chk("rst_data", data_o, 32'h0);
        chk("rst_dbg", dbg_out_o, 32'h0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        rst_n = 1'b1;

        // Counter read at cycle 10 after reset release
        repeat (10) step();
        access(16'h8000, 1'b0, '0);
        chk("cnt_at_10", data_o, 32'd10);

        // Give every RAM and slow location a known value
        for (int i = 0; i < 1024; i++) access(16'(i), 1'b1, initv(i));
        for (int i = 0; i < 16; i++) access(16'hC000 | 16'(i), 1'b1, initv(i + 2000));

        // RAM store then immediate load
        access(16'h0005, 1'b1, 32'hDEAD_BEEF);
        chk("ram_stall", {31'd0, stall_o}, 32'd0);
        access(16'h0005, 1'b0, '0);
        chk("ram_load", data_o, 32'hDEAD_BEEF);
        access(16'h0405, 1'b0, '0);
        chk("ram_alias", data_o, 32'hDEAD_BEEF);

        // ID register is read-only
        access(16'h8003, 1'b0, '0);
        chk("id_load", data_o, 32'h5645_4E55);
        access(16'h8003, 1'b1, 32'h1234);
        access(16'h8003, 1'b0, '0);
        chk("id_ro", data_o, 32'h5645_4E55);

        // Debug register
        access(16'h8002, 1'b1, 32'hA5);
        chk("dbg_out", dbg_out_o, 32'hA5);
        access(16'h8001, 1'b1, 32'h5C5C);
        access(16'h8002, 1'b0, '0);
        chk("dbg_load", data_o, 32'hA5);
        access(16'h8001, 1'b0, '0);
        chk("scratch_load", data_o, 32'h5C5C);

        // Slow store timing, cycle by cycle
        req = 1'b1; addr = 16'hC002; wr = 1'b1; din = 32'h77;
        #1;
        chk("slow_n0_stall", {31'd0, stall_o}, 32'd1);
        chk("slow_n0_busy", {31'd0, busy_o}, 32'd0);
        step();
        chk("slow_n1_stall", {31'd0, stall_o}, 32'd1);
        chk("slow_n1_busy", {31'd0, busy_o}, 32'd1);
        step();
        chk("slow_n2_stall", {31'd0, stall_o}, 32'd1);
        chk("slow_n2_busy", {31'd0, busy_o}, 32'd1);
        step();
        chk("slow_n3_stall", {31'd0, stall_o}, 32'd0);
        chk("slow_n3_busy", {31'd0, busy_o}, 32'd1);
        step();
        req = 1'b0;
        #1;
        chk("slow_n4_busy", {31'd0, busy_o}, 32'd0);
        access(16'hC002, 1'b0, '0);
        chk("slow_load", data_o, 32'h77);

        // Counter wrap
        dut.cyc_cnt = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        access(16'h8000, 1'b0, '0);
        chk("cnt_max", data_o, 32'hFFFF_FFFF);
        access(16'h8000, 1'b0, '0);
        chk("cnt_wrap", data_o, 32'h0);

        // Request withdrawn mid-wait: no store happens
        req = 1'b1; addr = 16'hC003; wr = 1'b1; din = 32'h5555;
        step(); step();
        req = 1'b0;
        step(); step();
        access(16'hC003, 1'b0, '0);
        chk("slow_abort", data_o, initv(2003));

        // Reset during the wait of a slow store
        access(16'hC001, 1'b1, 32'h11);
        req = 1'b1; addr = 16'hC001; wr = 1'b1; din = 32'h99;
        step();
        rst_n = 1'b0;
        #1;
        chk("rstw_stall", {31'd0, stall_o}, 32'd0);
        chk("rstw_busy", {31'd0, busy_o}, 32'd0);
        req = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        access(16'hC001, 1'b0, '0);
        chk("rstw_load", data_o, 32'h11);

        // Randomized traffic, back-to-back with occasional idles
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                step();
            end else begin
                ra = 16'($urandom);
                if (ra[15:14] == 2'b10) ra[13:2] = '0;
                access(ra, 1'($urandom_range(0, 1)), $urandom);
            end
        end
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the load/store interface driven by the execute stage.
- Decodes each address into one of three regions: on-chip RAM, memory-mapped registers (MMIO), or a slow wait-stated region.
- Returns load data one cycle after a request is accepted.
- Holds the pipeline through `stall_o` while a slow-region access completes.

Parameters:
- ADDR, 16, address width (word addresses).
- W_OPR, 32, data width.
- DEPTH_LOG2, 10, log2 of RAM depth in words.
- WAIT_CYCLES, 3, stall cycles per slow-region access (legal range 1..15).
- SLOW_LOG2, 4, log2 of slow-region register-array depth.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_i  in  1  request valid this cycle.
- addr_i  in  ADDR  word address.
- write_i  in  1  1 = store, 0 = load.
- data_i  in  W_OPR  store data.
- data_o  out  W_OPR  load data (registered).
- stall_o  out  1  request not accepted; requester holds req/addr/write/data.
- dbg_out_o  out  W_OPR  value of the MMIO debug-output register.
- busy_o  out  1  slow-region FSM not IDLE.

Behaviour:
- Clocking/reset: one clock `clk`; `reset` is asynchronous and active-low.
- Reset values:
  - data_o = 0, dbg_out_o = 0, scratch = 0, cycle counter = 0, FSM = IDLE, busy_o = 0.
  - stall_o = 0 whenever req_i = 0.
  - RAM and slow-array contents are not reset.
- Region decode on addr_i[ADDR-1:ADDR-2]:
  - 00 or 01: RAM, index addr_i[DEPTH_LOG2-1:0] (aliases above the depth).
  - 10: MMIO, offset addr_i[1:0].
  - 11: slow region, index addr_i[SLOW_LOG2-1:0].
- Acceptance: a request is accepted in any cycle with req_i = 1 and stall_o = 0.
- Store commit: at the rising edge ending the accept cycle.
- Load return:
  - data_o updates at that same edge, so it is valid from the next cycle.
  - data_o holds its value until the next accepted load.
  - Accepted stores and idle cycles leave data_o unchanged.
- RAM timing:
  - Zero wait states; stall_o is never asserted for RAM.
  - A store at cycle N followed by a load of the same address at N+1 returns the new data.
- MMIO registers:
  - Offset 0: free-running cycle counter, read-only. Increments every cycle after reset and wraps from 0xFFFFFFFF to 0. A load returns the value present in the accept cycle.
  - Offset 1: scratch, read/write.
  - Offset 2: debug output, read/write, drives dbg_out_o (visible the cycle after the store).
  - Offset 3: ID, read-only, constant 0x56454E55.
  - Stores to read-only offsets are ignored.
- Slow-region FSM, states IDLE and WAIT, with a 4-bit down-counter `cnt`:
  - IDLE, slow request present: stall_o = 1 combinationally; go to WAIT with cnt = WAIT_CYCLES-1.
  - WAIT, cnt != 0: stall_o = 1; decrement cnt.
  - WAIT, cnt == 0: stall_o = 0; the request is accepted and performed like RAM; return to IDLE.
  - Net timing: a slow access presented at cycle N stalls cycles N..N+WAIT_CYCLES-1, is accepted at N+WAIT_CYCLES, and its load data is valid at N+WAIT_CYCLES+1.
  - busy_o = 1 in WAIT.
  - If req_i drops while in WAIT, the FSM returns to IDLE and no access is performed (protocol violation, handled safely).
- Back-to-back accepted requests are supported every cycle; a slow access immediately following another slow access restarts the wait.
- Reset mid-WAIT: FSM goes to IDLE, the pending store is discarded, and stall_o deasserts immediately.
- Undefined addresses do not exist; every address maps to a location.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x0005, then load 0x0005 in the next cycle: data_o = 0xDEADBEEF one cycle after the load; stall_o stays 0 throughout.
- Load MMIO 0x8003: data_o = 0x56454E55. Store 0x1234 to 0x8003, then reload: still 0x56454E55.
- Store 0xA5 to 0x8002: dbg_out_o = 0xA5 the next cycle. Load 0x8002: returns 0xA5.
- Counter: load 0x8000 at cycle 10 after reset release (counter 0 at cycle 0): data_o = 10. Force the counter to 0xFFFFFFFF: it reads 0 one cycle later.
- Slow path, WAIT_CYCLES = 3:
  - Store 0x77 to 0xC002 at cycle N: stall_o high at N..N+2, low at N+3, busy_o high at N+1..N+3.
  - Load 0xC002 next: data_o = 0x77 at the fourth cycle after its presentation.
- Assert reset during WAIT of a slow store of 0x99 to 0xC001 (previously 0x11): stall_o and busy_o drop to 0 immediately; a later load of 0xC001 returns 0x11.
